// File: rtl/vga_csr_pkg.sv
// Shared register map, field positions and reset constants for the VGA
// control/status register block. The bench imports this too, so offsets and
// reset values are defined in exactly one place.
package vga_csr_pkg;

  localparam int CSR_ADDR_W = 8;
  localparam int CSR_DATA_W = 32;

  // Byte offsets of every register in the map
  localparam logic [7:0] CSR_CTRL        = 8'h00;
  localparam logic [7:0] CSR_STATUS      = 8'h04;
  localparam logic [7:0] CSR_FB_BASE     = 8'h08;
  localparam logic [7:0] CSR_H_TIMING    = 8'h0C;
  localparam logic [7:0] CSR_V_TIMING    = 8'h10;
  localparam logic [7:0] CSR_INT_STATUS  = 8'h14;
  localparam logic [7:0] CSR_INT_ENABLE  = 8'h18;
  localparam logic [7:0] CSR_FRAME_COUNT = 8'h1C;
  localparam logic [7:0] CSR_SCRATCH     = 8'h20;
  localparam logic [7:0] CSR_ID          = 8'h24;

  // Word index of each register; the two low address bits never decode
  typedef enum logic [5:0] {
    REG_CTRL        = CSR_CTRL[7:2],
    REG_STATUS      = CSR_STATUS[7:2],
    REG_FB_BASE     = CSR_FB_BASE[7:2],
    REG_H_TIMING    = CSR_H_TIMING[7:2],
    REG_V_TIMING    = CSR_V_TIMING[7:2],
    REG_INT_STATUS  = CSR_INT_STATUS[7:2],
    REG_INT_ENABLE  = CSR_INT_ENABLE[7:2],
    REG_FRAME_COUNT = CSR_FRAME_COUNT[7:2],
    REG_SCRATCH     = CSR_SCRATCH[7:2],
    REG_ID          = CSR_ID[7:2]
  } csr_reg_e;

  // Field positions
  localparam int CTRL_W                = 2;
  localparam int CTRL_ENABLE_BIT       = 0;
  localparam int CTRL_TEST_PATTERN_BIT = 1;
  localparam int STATUS_PENDING_BIT    = 0;
  localparam int INT_W                 = 2;
  localparam int INT_VSYNC_BIT         = 0;
  localparam int INT_UNDERFLOW_BIT     = 1;
  localparam int TIMING_W              = 12;
  localparam int TIMING_ACTIVE_LSB     = 0;
  localparam int TIMING_TOTAL_LSB      = 16;

  // Reset constants (640x480 @ 800x525 totals)
  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5647_4131;
  localparam logic [31:0] FB_BASE_RESET    = 32'h0000_0000;
  localparam logic [31:0] H_TIMING_RESET   = 32'h0320_0280;
  localparam logic [31:0] V_TIMING_RESET   = 32'h020D_01E0;

  // Only the implemented timing bits are stored
  typedef struct packed {
    logic [TIMING_W-1:0] total;
    logic [TIMING_W-1:0] active;
  } timing_t;

  localparam timing_t H_SHADOW_RESET = {H_TIMING_RESET[TIMING_TOTAL_LSB +: TIMING_W],
                                        H_TIMING_RESET[TIMING_ACTIVE_LSB +: TIMING_W]};
  localparam timing_t V_SHADOW_RESET = {V_TIMING_RESET[TIMING_TOTAL_LSB +: TIMING_W],
                                        V_TIMING_RESET[TIMING_ACTIVE_LSB +: TIMING_W]};

  // Expands a stored timing pair back into its register layout
  function automatic logic [31:0] timing_word(input timing_t t);
    logic [31:0] w;
    w = '0;
    w[TIMING_TOTAL_LSB +: TIMING_W]  = t.total;
    w[TIMING_ACTIVE_LSB +: TIMING_W] = t.active;
    return w;
  endfunction

endpackage

// File: rtl/vga_shadow_reg.sv
// One shadow/active register pair. Software writes land in the shadow; the
// active copy that drives the display pipeline only changes on commit, and
// always takes the shadow value as it stood before any same-edge write.
module vga_shadow_reg
  import vga_csr_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit,
  output logic [WIDTH-1:0] shadow_q,
  output logic [WIDTH-1:0] active_q
);

  logic [WIDTH-1:0] shadow_d;
  logic [WIDTH-1:0] active_d;

  // Next-state: shadow follows writes, active copies the old shadow on commit
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en) shadow_d = wr_data;
    if (commit) active_d = shadow_q;
  end

  // Shadow and active state, both reset to the same value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= RESET_VALUE;
      active_q <= RESET_VALUE;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/vga_csr_regs.sv
// VGA controller CSR block: control, double-buffered framebuffer/timing
// registers, sticky interrupt status with W1C clear, frame counter, scratch
// and ID. Read data is registered and held until the next read.
module vga_csr_regs
  import vga_csr_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CSR_ADDR_W-1:0] csr_address,
  input  logic                  csr_write,
  input  logic                  csr_read,
  input  logic [CSR_DATA_W-1:0] csr_wr_data,
  output logic [CSR_DATA_W-1:0] csr_rd_data,
  input  logic                  frame_start,
  input  logic                  underflow,
  output logic                  vga_enable,
  output logic                  test_pattern,
  output logic [31:0]           fb_base,
  output logic [TIMING_W-1:0]   h_active,
  output logic [TIMING_W-1:0]   h_total,
  output logic [TIMING_W-1:0]   v_active,
  output logic [TIMING_W-1:0]   v_total,
  output logic                  irq
);

  csr_reg_e addr_reg;
  logic     unused_addr_bits;

  logic wr_ctrl, wr_fb, wr_h, wr_v, wr_int_status, wr_int_enable, wr_scratch;
  logic shadow_wr;
  logic commit;
  logic [INT_W-1:0] int_set;
  logic [INT_W-1:0] int_clr;
  logic [31:0] rd_mux;

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              update_pending_q, update_pending_d;
  logic [INT_W-1:0]  int_status_q, int_status_d;
  logic [INT_W-1:0]  int_enable_q, int_enable_d;
  logic [31:0]       frame_count_q, frame_count_d;
  logic [31:0]       scratch_q, scratch_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              irq_q, irq_d;

  logic [31:0] fb_shadow, fb_active;
  timing_t     timing_wr;
  timing_t     h_shadow, h_active_r;
  timing_t     v_shadow, v_active_r;

  assign addr_reg         = csr_reg_e'(csr_address[7:2]);
  assign unused_addr_bits = ^csr_address[1:0];
  assign timing_wr        = {csr_wr_data[TIMING_TOTAL_LSB +: TIMING_W],
                             csr_wr_data[TIMING_ACTIVE_LSB +: TIMING_W]};

  // Decode write strobes; unmapped and read-only words get no strobe
  always_comb begin
    wr_ctrl       = 1'b0;
    wr_fb         = 1'b0;
    wr_h          = 1'b0;
    wr_v          = 1'b0;
    wr_int_status = 1'b0;
    wr_int_enable = 1'b0;
    wr_scratch    = 1'b0;
    if (csr_write) begin
      case (addr_reg)
        REG_CTRL:       wr_ctrl       = 1'b1;
        REG_FB_BASE:    wr_fb         = 1'b1;
        REG_H_TIMING:   wr_h          = 1'b1;
        REG_V_TIMING:   wr_v          = 1'b1;
        REG_INT_STATUS: wr_int_status = 1'b1;
        REG_INT_ENABLE: wr_int_enable = 1'b1;
        REG_SCRATCH:    wr_scratch    = 1'b1;
        default:        ;
      endcase
    end
  end

  // Read mux over current register state, so a same-cycle write returns the old value
  always_comb begin
    rd_mux = '0;
    case (addr_reg)
      REG_CTRL:        rd_mux[CTRL_W-1:0]        = ctrl_q;
      REG_STATUS:      rd_mux[STATUS_PENDING_BIT] = update_pending_q;
      REG_FB_BASE:     rd_mux                    = fb_shadow;
      REG_H_TIMING:    rd_mux                    = timing_word(h_shadow);
      REG_V_TIMING:    rd_mux                    = timing_word(v_shadow);
      REG_INT_STATUS:  rd_mux[INT_W-1:0]         = int_status_q;
      REG_INT_ENABLE:  rd_mux[INT_W-1:0]         = int_enable_q;
      REG_FRAME_COUNT: rd_mux                    = frame_count_q;
      REG_SCRATCH:     rd_mux                    = scratch_q;
      REG_ID:          rd_mux                    = ID_VALUE;
      default:         rd_mux                    = '0;
    endcase
  end

  // Next-state for all flat registers; a shadow write outranks a commit's clear of pending
  always_comb begin
    shadow_wr = wr_fb | wr_h | wr_v;
    commit    = !ctrl_q[CTRL_ENABLE_BIT] || (update_pending_q && frame_start);

    ctrl_d = ctrl_q;
    if (wr_ctrl) ctrl_d = csr_wr_data[CTRL_W-1:0];

    update_pending_d = update_pending_q;
    if (commit) update_pending_d = 1'b0;
    if (shadow_wr) update_pending_d = 1'b1;

    int_set                    = '0;
    int_set[INT_VSYNC_BIT]     = frame_start;
    int_set[INT_UNDERFLOW_BIT] = underflow;
    int_clr                    = wr_int_status ? csr_wr_data[INT_W-1:0] : '0;
    int_status_d               = (int_status_q & ~int_clr) | int_set;

    int_enable_d = int_enable_q;
    if (wr_int_enable) int_enable_d = csr_wr_data[INT_W-1:0];

    frame_count_d = frame_count_q;
    if (ctrl_q[CTRL_ENABLE_BIT] && frame_start) frame_count_d = frame_count_q + 32'd1;

    scratch_d = scratch_q;
    if (wr_scratch) scratch_d = csr_wr_data;

    irq_d     = |(int_status_q & int_enable_q);
    rd_data_d = csr_read ? rd_mux : rd_data_q;
  end

  // Register state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q           <= '0;
      update_pending_q <= 1'b0;
      int_status_q     <= '0;
      int_enable_q     <= '0;
      frame_count_q    <= '0;
      scratch_q        <= '0;
      rd_data_q        <= '0;
      irq_q            <= 1'b0;
    end else begin
      ctrl_q           <= ctrl_d;
      update_pending_q <= update_pending_d;
      int_status_q     <= int_status_d;
      int_enable_q     <= int_enable_d;
      frame_count_q    <= frame_count_d;
      scratch_q        <= scratch_d;
      rd_data_q        <= rd_data_d;
      irq_q            <= irq_d;
    end
  end

  vga_shadow_reg #(.WIDTH(32), .RESET_VALUE(FB_BASE_RESET)) u_fb_base (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_fb),
    .wr_data  (csr_wr_data),
    .commit   (commit),
    .shadow_q (fb_shadow),
    .active_q (fb_active)
  );

  vga_shadow_reg #(.WIDTH($bits(timing_t)), .RESET_VALUE(H_SHADOW_RESET)) u_h_timing (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_h),
    .wr_data  (timing_wr),
    .commit   (commit),
    .shadow_q (h_shadow),
    .active_q (h_active_r)
  );

  vga_shadow_reg #(.WIDTH($bits(timing_t)), .RESET_VALUE(V_SHADOW_RESET)) u_v_timing (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_v),
    .wr_data  (timing_wr),
    .commit   (commit),
    .shadow_q (v_shadow),
    .active_q (v_active_r)
  );

  assign csr_rd_data  = rd_data_q;
  assign irq          = irq_q;
  assign vga_enable   = ctrl_q[CTRL_ENABLE_BIT];
  assign test_pattern = ctrl_q[CTRL_TEST_PATTERN_BIT];
  assign fb_base      = fb_active;
  assign h_active     = h_active_r.active;
  assign h_total      = h_active_r.total;
  assign v_active     = v_active_r.active;
  assign v_total      = v_active_r.total;

endmodule

// File: tb/tb_vga_csr_regs.sv
// Self-checking bench for vga_csr_regs. Read expectations are queued when a
// read is issued and popped by a monitor when the registered data appears;
// side-band outputs are compared directly after each cycle.
module tb_vga_csr_regs;
  import vga_csr_pkg::*;

  localparam logic [31:0] ID = 32'h5647_4131;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  csr_address = '0;
  logic        csr_write = 1'b0;
  logic        csr_read = 1'b0;
  logic [31:0] csr_wr_data = '0;
  logic [31:0] csr_rd_data;
  logic        frame_start = 1'b0;
  logic        underflow = 1'b0;
  logic        vga_enable, test_pattern, irq;
  logic [31:0] fb_base;
  logic [11:0] h_active, h_total, v_active, v_total;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen;
  logic [31:0] mon_exp;
  string       mon_name;

  vga_csr_regs #(.ID_VALUE(ID)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .csr_address  (csr_address),
    .csr_write    (csr_write),
    .csr_read     (csr_read),
    .csr_wr_data  (csr_wr_data),
    .csr_rd_data  (csr_rd_data),
    .frame_start  (frame_start),
    .underflow    (underflow),
    .vga_enable   (vga_enable),
    .test_pattern (test_pattern),
    .fb_base      (fb_base),
    .h_active     (h_active),
    .h_total      (h_total),
    .v_active     (v_active),
    .v_total      (v_total),
    .irq          (irq)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Remembers that a read strobe was sampled, so the monitor knows data is due
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_seen <= 1'b0;
    else          rd_seen <= csr_read;
  end

  // Monitor: pops the oldest expected read value when registered data is presented
  always @(negedge clk) begin
    if (rd_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_read: got %h, required no read data", csr_rd_data);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (csr_rd_data !== mon_exp) begin
          failures++;
          $display("[TB] FAIL %s: got %h, required %h", mon_name, csr_rd_data, mon_exp);
        end
      end
    end
  end

  // Watchdog so a hung run still ends with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // Drives one cycle of strobes across a single rising edge, returning at the next falling edge
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic fs, input logic uf);
    csr_write   = wr;
    csr_read    = rd;
    csr_address = addr;
    csr_wr_data = wdata;
    frame_start = fs;
    underflow   = uf;
    @(negedge clk);
    csr_write   = 1'b0;
    csr_read    = 1'b0;
    frame_start = 1'b0;
    underflow   = 1'b0;
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, data, 1'b0, 1'b0);
  endtask

  task automatic read_expect(input logic [7:0] addr, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    applyStimulus(1'b0, 1'b1, addr, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic pulse_frame();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] starting vga_csr_regs test");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset values
    checkOutput("reset_rd_data", csr_rd_data, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    checkOutput("reset_vga_enable", {31'b0, vga_enable}, 32'h0);
    checkOutput("reset_test_pattern", {31'b0, test_pattern}, 32'h0);
    checkOutput("reset_fb_base", fb_base, 32'h0);
    checkOutput("reset_h_active", {20'b0, h_active}, 32'd640);
    checkOutput("reset_h_total", {20'b0, h_total}, 32'd800);
    checkOutput("reset_v_active", {20'b0, v_active}, 32'd480);
    checkOutput("reset_v_total", {20'b0, v_total}, 32'd525);

    // Reset register contents through the bus
    read_expect(CSR_H_TIMING, 32'h0320_0280, "rd_h_timing_reset");
    read_expect(CSR_V_TIMING, 32'h020D_01E0, "rd_v_timing_reset");
    read_expect(CSR_ID, ID, "rd_id");
    idle(1);
    checkOutput("rd_data_hold", csr_rd_data, ID);
    read_expect(CSR_STATUS, 32'h0, "rd_status_reset");
    read_expect(CSR_FRAME_COUNT, 32'h0, "rd_frame_count_reset");

    // Disabled: active follows shadow one cycle later, frame count frozen
    write_reg(CSR_FB_BASE, 32'h0000_2000);
    checkOutput("disabled_fb_lag", fb_base, 32'h0);
    idle(1);
    checkOutput("disabled_fb_follow", fb_base, 32'h0000_2000);
    read_expect(CSR_STATUS, 32'h0, "rd_status_disabled");
    pulse_frame();
    read_expect(CSR_FRAME_COUNT, 32'h0, "rd_frame_count_disabled");

    // Enabled: shadow write waits for frame_start
    write_reg(CSR_CTRL, 32'h1);
    checkOutput("vga_enable_set", {31'b0, vga_enable}, 32'h1);
    write_reg(CSR_FB_BASE, 32'h0010_0000);
    checkOutput("fb_base_held", fb_base, 32'h0000_2000);
    read_expect(CSR_STATUS, 32'h1, "rd_status_pending");
    checkOutput("fb_base_still_held", fb_base, 32'h0000_2000);
    pulse_frame();
    checkOutput("fb_base_commit", fb_base, 32'h0010_0000);
    read_expect(CSR_STATUS, 32'h0, "rd_status_cleared");
    read_expect(CSR_FB_BASE, 32'h0010_0000, "rd_fb_base_shadow");

    // Shadow write coincident with frame_start commits the old shadow values
    write_reg(CSR_V_TIMING, 32'h0271_0258);
    applyStimulus(1'b1, 1'b0, CSR_H_TIMING, 32'hF400_F300, 1'b1, 1'b0);
    checkOutput("coinc_h_active", {20'b0, h_active}, 32'd640);
    checkOutput("coinc_h_total", {20'b0, h_total}, 32'd800);
    checkOutput("coinc_v_active", {20'b0, v_active}, 32'd600);
    checkOutput("coinc_v_total", {20'b0, v_total}, 32'd625);
    read_expect(CSR_STATUS, 32'h1, "rd_status_still_pending");
    pulse_frame();
    checkOutput("second_h_active", {20'b0, h_active}, 32'd768);
    checkOutput("second_h_total", {20'b0, h_total}, 32'd1024);
    read_expect(CSR_H_TIMING, 32'h0400_0300, "rd_h_timing_masked");
    read_expect(CSR_FRAME_COUNT, 32'd3, "rd_frame_count_3");

    // Interrupt status, W1C and irq timing
    write_reg(CSR_INT_STATUS, 32'h3);
    read_expect(CSR_INT_STATUS, 32'h0, "rd_int_status_clear");
    write_reg(CSR_INT_ENABLE, 32'h1);
    checkOutput("irq_idle", {31'b0, irq}, 32'h0);
    pulse_frame();
    checkOutput("irq_lag", {31'b0, irq}, 32'h0);
    idle(1);
    checkOutput("irq_set", {31'b0, irq}, 32'h1);
    read_expect(CSR_INT_STATUS, 32'h1, "rd_int_status_vsync");
    applyStimulus(1'b1, 1'b0, CSR_INT_STATUS, 32'h1, 1'b1, 1'b0);
    read_expect(CSR_INT_STATUS, 32'h1, "rd_int_set_wins");
    checkOutput("irq_kept", {31'b0, irq}, 32'h1);
    write_reg(CSR_INT_STATUS, 32'h1);
    checkOutput("irq_clear_lag", {31'b0, irq}, 32'h1);
    idle(1);
    checkOutput("irq_cleared", {31'b0, irq}, 32'h0);
    read_expect(CSR_INT_STATUS, 32'h0, "rd_int_status_w1c");
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
    read_expect(CSR_INT_STATUS, 32'h2, "rd_int_status_underflow");
    checkOutput("irq_masked", {31'b0, irq}, 32'h0);
    write_reg(CSR_INT_ENABLE, 32'hFFFF_FFFF);
    read_expect(CSR_INT_ENABLE, 32'h3, "rd_int_enable_masked");
    checkOutput("irq_underflow", {31'b0, irq}, 32'h1);

    // Scratch, read-during-write, unmapped and read-only addresses
    exp_q.push_back(32'h0);
    name_q.push_back("rd_scratch_prewrite");
    applyStimulus(1'b1, 1'b1, CSR_SCRATCH, 32'hA5A5_5A5A, 1'b0, 1'b0);
    read_expect(CSR_SCRATCH, 32'hA5A5_5A5A, "rd_scratch");
    read_expect(8'h23, 32'hA5A5_5A5A, "rd_scratch_low_bits");
    read_expect(8'h80, 32'h0, "rd_unmapped");
    write_reg(8'h80, 32'hFFFF_FFFF);
    write_reg(CSR_ID, 32'h0);
    read_expect(CSR_ID, ID, "rd_id_ro");
    write_reg(CSR_FRAME_COUNT, 32'h1234);
    read_expect(CSR_FRAME_COUNT, 32'd5, "rd_frame_count_ro");
    write_reg(CSR_CTRL, 32'hFFFF_FFFF);
    checkOutput("test_pattern_set", {31'b0, test_pattern}, 32'h1);
    read_expect(CSR_CTRL, 32'h3, "rd_ctrl_masked");
    write_reg(CSR_CTRL, 32'h1);

    // Frame counter wrap via backdoor preload
    force dut.frame_count_d = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.frame_count_d;
    read_expect(CSR_FRAME_COUNT, 32'hFFFF_FFFE, "rd_frame_count_preload");
    pulse_frame();
    read_expect(CSR_FRAME_COUNT, 32'hFFFF_FFFF, "rd_frame_count_max");
    pulse_frame();
    read_expect(CSR_FRAME_COUNT, 32'h0, "rd_frame_count_wrap");

    // Reset in the middle of a scratch write discards it
    csr_write   = 1'b1;
    csr_address = CSR_SCRATCH;
    csr_wr_data = 32'hDEAD_BEEF;
    #2 reset_n = 1'b0;
    @(negedge clk);
    csr_write = 1'b0;
    reset_n   = 1'b1;
    read_expect(CSR_SCRATCH, 32'h0, "rd_scratch_after_reset");
    read_expect(CSR_H_TIMING, 32'h0320_0280, "rd_h_timing_after_reset");
    checkOutput("fb_base_after_reset", fb_base, 32'h0);
    checkOutput("vga_enable_after_reset", {31'b0, vga_enable}, 32'h0);

    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL read_queue_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_csr_regs.md
VGA_CSR_REGS -- requirements
Module: vga_csr_regs

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h5647_4131, constant returned by the ID register.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic on posedge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port csr_address, input, 8: byte address, word-aligned; bits [1:0] ignored.
REQ-005 SHALL have port csr_write, input, 1: single-cycle write strobe.
REQ-006 SHALL have port csr_read, input, 1: single-cycle read strobe.
REQ-007 SHALL have port csr_wr_data, input, 32: write data.
REQ-008 SHALL have port csr_rd_data, output, 32: registered read data.
REQ-009 SHALL have port frame_start, input, 1: one-cycle pulse at start of vertical blank.
REQ-010 SHALL have port underflow, input, 1: one-cycle pixel FIFO underflow pulse.
REQ-011 SHALL have outputs vga_enable (1), test_pattern (1), fb_base (32), h_active (12), h_total (12), v_active (12), v_total (12), irq (1), all registered.

Function
REQ-012 Map SHALL be: 0x00 CTRL RW [0]=enable [1]=test_pattern; 0x04 STATUS RO [0]=update_pending; 0x08 FB_BASE RW; 0x0C H_TIMING RW [11:0]=h_active [27:16]=h_total; 0x10 V_TIMING RW [11:0]=v_active [27:16]=v_total; 0x14 INT_STATUS W1C [0]=vsync [1]=underflow; 0x18 INT_ENABLE RW [1:0]; 0x1C FRAME_COUNT RO; 0x20 SCRATCH RW; 0x24 ID RO.
REQ-013 Writes SHALL take effect in the register on the clock edge where csr_write=1; unimplemented bits SHALL read 0.
REQ-014 Read latency SHALL be 1 cycle: csr_rd_data valid the cycle after csr_read=1, then held until the next read.
REQ-015 Unmapped addresses SHALL read 32'd0; writes to them and to RO registers SHALL be ignored.
REQ-016 Simultaneous csr_read and csr_write SHALL perform the write and return the pre-write value.
REQ-017 FB_BASE/H_TIMING/V_TIMING SHALL be shadow registers; reads return shadow values; a write to any of them SHALL set update_pending.
REQ-018 When update_pending=1 and frame_start=1, active outputs SHALL load from shadows and update_pending SHALL clear, next edge.
REQ-019 Shadow write coincident with frame_start: commit SHALL use pre-write shadow values and update_pending SHALL remain 1.
REQ-020 When CTRL.enable=0, active outputs SHALL load from shadows every cycle (1-cycle latency) and update_pending SHALL clear.
REQ-021 frame_start SHALL set INT_STATUS[0]; underflow SHALL set INT_STATUS[1]; writing 1 clears a bit; set SHALL win over simultaneous clear.
REQ-022 irq SHALL equal registered OR of (INT_STATUS & INT_ENABLE), one cycle after the contributing state change.
REQ-023 FRAME_COUNT SHALL increment by 1 per frame_start when enable=1, wrapping 32'hFFFF_FFFF -> 0.

Reset
REQ-024 On reset_n=0 all state SHALL reset asynchronously: CTRL=0, FB_BASE=0, H_TIMING=32'h0320_0280 (640/800), V_TIMING=32'h020D_01E0 (480/525), INT_STATUS=0, INT_ENABLE=0, FRAME_COUNT=0, SCRATCH=0, update_pending=0, csr_rd_data=0, irq=0.
REQ-025 Active timing outputs SHALL reset to the same values as their shadows; vga_enable=0, test_pattern=0, fb_base=0.
REQ-026 Reset asserted mid-access SHALL discard the access; no partial write survives.

Structure
REQ-027 Register offsets, field bit positions and reset constants SHALL live in shared package vga_csr_pkg, also used by the bench stimulus.
REQ-028 The shadow/active commit logic SHALL be one sub-module, vga_shadow_reg, instanced once per shadowed register; everything else flat.

Verification
REQ-029 After reset, read 0x0C, 0x10, 0x24 -> 32'h0320_0280, 32'h020D_01E0, ID_VALUE, each one cycle after csr_read.
REQ-030 enable=1, write 0x08=32'h0010_0000 -> STATUS=1, fb_base unchanged; pulse frame_start -> fb_base=32'h0010_0000 next cycle, STATUS=0.
REQ-031 Write 0x0C coincident with frame_start -> h_* unchanged, STATUS=1; second frame_start -> new value applied.
REQ-032 INT_ENABLE=1, frame_start -> INT_STATUS=1, irq=1 one cycle later; write 0x14=1 together with frame_start -> bit stays 1; write 0x14=1 alone -> irq=0.
REQ-033 Write SCRATCH=32'hA5A5_5A5A with simultaneous read of 0x20 -> old value 0; next read -> 32'hA5A5_5A5A; read 0x80 -> 0.
REQ-034 Force FRAME_COUNT to 32'hFFFF_FFFE via 2^32-2 pulses (or backdoor), two frame_starts -> 0; reset mid-write to SCRATCH -> reads 0.
